// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns with valid/ready flow.
// Define SHIFT_ROWS_PIPE_INV_EN to build the inverse permutation selected per transaction by in_inv.
module shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [32*NB-1:0] state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [32*NB-1:0] state_out
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: PIPE_STAGES must be in 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Rows 2 and 3 shift one column further on the 256-bit block.
  function automatic int row_shift(input int r);
    int s;
    s = r;
    if (NB == 8 && r >= 2) s = r + 1;
    return s;
  endfunction

  function automatic logic [W-1:0] shift_fwd(input logic [W-1:0] s);
    logic [W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c + row_shift(r)) % NB) + r) +: 8];
      end
    end
    return o;
  endfunction

  logic [W-1:0] perm_d;

`ifdef SHIFT_ROWS_PIPE_INV_EN
  function automatic logic [W-1:0] shift_inv(input logic [W-1:0] s);
    logic [W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c - row_shift(r) + NB) % NB) + r) +: 8];
      end
    end
    return o;
  endfunction

  assign perm_d = in_inv ? shift_inv(state_in) : shift_fwd(state_in);
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign perm_d     = shift_fwd(state_in);
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready; ready never
  // depends on valid of the same interface, and a held output stays frozen until taken.
  logic [PIPE_STAGES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic [W-1:0]           data_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] advance;

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    logic carry;
    advance = '0;
    carry   = out_ready;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      carry      = carry || !valid_q[i];
      advance[i] = carry;
    end
  end

  assign in_ready = advance[0] && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (advance[0]) begin
        valid_q[0] <= in_valid;
        tag_q[0]   <= in_tag;
        data_q[0]  <= perm_d;
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (advance[i]) begin
          valid_q[i] <= valid_q[i-1];
          tag_q[i]   <= tag_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign state_out = data_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4/P=1 vectors, NB=8/P=2 offsets, NB=4/P=3 streaming with a scoreboard.
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_PIPE_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  localparam logic [127:0] VEC_IN  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
  localparam logic [127:0] VEC_FWD = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut_a: NB=4, PIPE_STAGES=1
  logic         a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [3:0]   a_in_tag, a_out_tag;
  logic [127:0] a_state_in, a_state_out;
  // dut_b: NB=8, PIPE_STAGES=2
  logic         b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [255:0] b_state_in, b_state_out;
  // dut_c: NB=4, PIPE_STAGES=3
  logic         c_flush, c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
  logic [3:0]   c_in_tag, c_out_tag;
  logic [127:0] c_state_in, c_state_out;

  logic [131:0] exp_q[$];

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(1), .TAG_W(4)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_tag(a_in_tag), .state_in(a_state_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_tag(a_out_tag), .state_out(a_state_out));

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(2), .TAG_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_tag(b_in_tag), .state_in(b_state_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_tag(b_out_tag), .state_out(b_state_out));

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(3), .TAG_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_inv(c_in_inv), .in_tag(c_in_tag), .state_in(c_state_in), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_tag(c_out_tag), .state_out(c_state_out));

  task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each input byte is scattered to its destination column.
  function automatic logic [255:0] sr_model(input logic [255:0] s, input int nb, input bit inv);
    logic [255:0] o;
    int off, dst;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        dst = inv ? (c + off) % nb : (c - off + nb) % nb;
        o[8*(4*dst+r) +: 8] = s[8*(4*c+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] model4(input logic [127:0] s, input bit inv);
    logic [255:0] m;
    m = sr_model({128'h0, s}, 4, inv && INV_ON);
    return m[127:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle of dut_c: inputs already driven at the negedge; score, then advance one clock.
  task automatic c_step(output bit acc);
    bit fire_out;
    #1;
    check("c_in_ready", c_in_ready, (!c_flush) && ((exp_q.size() < 3) || c_out_ready));
    if (exp_q.size() == 0) check("c_idle_valid", c_out_valid, 1'b0);
    else if (c_out_valid) check("c_out", {c_out_tag, c_state_out}, exp_q[0]);
    fire_out = c_out_valid && c_out_ready;
    acc = c_in_valid && c_in_ready;
    if (fire_out && exp_q.size() > 0) void'(exp_q.pop_front());
    if (c_flush) exp_q.delete();
    else if (acc) exp_q.push_back({c_in_tag, model4(c_state_in, c_in_inv)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic c_latency(input logic [3:0] t);
    bit acc;
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    c_in_tag    = t;
    c_in_inv    = 1'($urandom_range(0, 1));
    c_state_in  = rand128();
    c_step(acc);
    c_in_valid = 1'b0;
    check("c_lat_accept", acc, 1'b1);
    check("c_lat_edge0", c_out_valid, 1'b0);
    c_step(acc);
    check("c_lat_edge1", c_out_valid, 1'b0);
    c_step(acc);
    check("c_lat_edge2", c_out_valid, 1'b1);
    c_step(acc);
    check("c_lat_drain", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_rt, d1, d2;
    logic [255:0] bytes_k;
    bit acc, inv1, inv2;
    int sent, cyc;

    reset = 1'b0;
    {a_flush, a_in_valid, a_in_inv, a_in_tag, a_state_in} = '0;
    {b_flush, b_in_valid, b_in_inv, b_in_tag, b_state_in} = '0;
    {c_flush, c_in_valid, c_in_inv, c_in_tag, c_state_in} = '0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;

    #3;
    check("rst_a_valid", a_out_valid, 1'b0);
    check("rst_a_data", a_state_out, 128'h0);
    check("rst_a_tag", a_out_tag, 4'h0);
    check("rst_a_ready", a_in_ready, 1'b1);
    check("rst_b_valid", b_out_valid, 1'b0);
    check("rst_b_data", b_state_out, 256'h0);
    check("rst_c_valid", c_out_valid, 1'b0);
    check("rst_c_ready", c_in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Known-answer vector and round trip on the single-stage pipe
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_tag = 4'h5; a_state_in = VEC_IN;
    #1 check("a_vec_ready", a_in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    check("a_vec_valid", a_out_valid, 1'b1);
    check("a_vec_data", a_state_out, VEC_FWD);
    check("a_vec_tag", a_out_tag, 4'h5);
    a_state_in = VEC_FWD; a_in_inv = 1'b1; a_in_tag = 4'ha;
    @(posedge clk); @(negedge clk);
    exp_rt = INV_ON ? VEC_IN : model4(VEC_FWD, 1'b0);
    check("a_rt_data", a_state_out, exp_rt);
    check("a_rt_tag", a_out_tag, 4'ha);
    a_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("a_idle_valid", a_out_valid, 1'b0);

    // Single-stage stall, then consume and accept on the same edge
    d1 = rand128(); d2 = rand128();
    inv1 = 1'($urandom_range(0, 1)); inv2 = 1'($urandom_range(0, 1));
    a_in_valid = 1'b1; a_state_in = d1; a_in_inv = inv1; a_in_tag = 4'h7;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0; a_state_in = d2; a_in_inv = inv2; a_in_tag = 4'h8;
    #1 check("a_stall_ready", a_in_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    check("a_hold_valid", a_out_valid, 1'b1);
    check("a_hold_data", a_state_out, model4(d1, inv1));
    check("a_hold_tag", a_out_tag, 4'h7);
    a_out_ready = 1'b1;
    #1 check("a_pass_ready", a_in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    check("a_pass_data", a_state_out, model4(d2, inv2));
    check("a_pass_tag", a_out_tag, 4'h8);

    // NB=8 offsets with byte k = k, forward then inverse
    for (int k = 0; k < 32; k++) bytes_k[8*k +: 8] = k[7:0];
    b_state_in = bytes_k; b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_tag = 4'h3;
    #1 check("b_ready", b_in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    check("b_lat_edge0", b_out_valid, 1'b0);
    b_in_inv = 1'b1; b_in_tag = 4'h9;
    @(posedge clk); @(negedge clk);
    check("b_fwd_valid", b_out_valid, 1'b1);
    check("b_row1_col0", b_state_out[15:8], 8'd5);
    check("b_row2_col0", b_state_out[23:16], 8'd14);
    check("b_row3_col0", b_state_out[31:24], 8'd19);
    check("b_fwd_data", b_state_out, sr_model(bytes_k, 8, 1'b0));
    check("b_fwd_tag", b_out_tag, 4'h3);
    b_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b_inv_data", b_state_out, sr_model(bytes_k, 8, INV_ON));
    check("b_inv_tag", b_out_tag, 4'h9);
    @(posedge clk); @(negedge clk);
    check("b_idle_valid", b_out_valid, 1'b0);

    // Three-stage latency
    c_latency(4'hd);

    // Backpressure stream of 10 tagged states, out_ready pattern 1,0,0
    sent = 0; cyc = 0;
    c_in_tag = 4'h0; c_state_in = rand128(); c_in_inv = 1'($urandom_range(0, 1));
    while ((sent < 10 || exp_q.size() != 0) && cyc < 300) begin
      c_out_ready = (cyc % 3 == 0);
      c_in_valid  = (sent < 10);
      c_step(acc);
      if (acc) begin
        sent++;
        c_in_tag   = sent[3:0];
        c_state_in = rand128();
        c_in_inv   = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    c_in_valid = 1'b0;
    check("bp_sent", sent, 10);
    check("bp_drain", exp_q.size(), 0);

    // Flush with two states loaded; input offered during the flush is ignored
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      c_in_tag = 4'(i + 1); c_state_in = rand128();
      c_step(acc);
    end
    c_flush = 1'b1; c_in_tag = 4'hf;
    c_step(acc);
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b1;
    check("flush_out_valid", c_out_valid, 1'b0);
    for (int i = 0; i < 4; i++) c_step(acc);

    // Flush coincident with a consumed output on a full pipe
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_in_tag = 4'(i + 4); c_state_in = rand128();
      c_step(acc);
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_flush = 1'b1;
    c_step(acc);
    c_flush = 1'b0;
    check("flush_rdy_valid", c_out_valid, 1'b0);
    for (int i = 0; i < 3; i++) c_step(acc);

    // Asynchronous reset between edges on a full pipe
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_in_tag = 4'(i + 8); c_state_in = rand128() | 128'h1;
      c_step(acc);
    end
    c_in_valid = 1'b0;
    check("pre_rst_valid", c_out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_c_valid", c_out_valid, 1'b0);
    check("arst_c_data", c_state_out, 128'h0);
    check("arst_c_tag", c_out_tag, 4'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    c_latency(4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, pipelined ShiftRows / InvShiftRows unit for Rijndael states of NB columns (4, 6 or 8). It serves as the next-generation row-permutation stage of the round datapath, placed between SubBytes and MixColumns. It adds a per-transaction direction select, a valid/ready handshake with a configurable register pipeline, a sideband tag, and a synchronous flush.

## Interface
- NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
- PIPE_STAGES, 1, register stages from input to output; legal range 1..4.
- TAG_W, 4, width of the sideband tag carried alongside the data; legal range ≥1.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_inv  in  1  0 = forward ShiftRows, 1 = InvShiftRows; sampled with the data.
- in_tag  in  TAG_W  sideband tag, delivered unchanged.
- state_in  in  32*NB  input state.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream ready.
- out_tag  out  TAG_W  tag of the current output.
- state_out  out  32*NB  permuted state.

## Operation
- Byte k occupies bits [8k+7:8k]. Row r = k mod 4 and column c = k div 4. Byte 0 is the LSB.
- Row shift offsets s(r):
  - NB=4 or 6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward: out(r,c) = in(r, (c + s(r)) mod NB).
- Inverse: out(r,c) = in(r, (c − s(r)) mod NB).
- The permutation is combinational on state_in and is captured into stage 1 on acceptance. Stages 2..PIPE_STAGES are pure delay.
- Each stage holds {valid, tag, data}.
- Stage i loads from stage i−1 when advance_i = !valid_i || advance_(i+1). The advance term of the last stage is !valid_last || out_ready.
- in_ready = advance_1 && !flush. This is combinational from out_ready through the chain, so there are no bubbles and throughput is one state per cycle.
- A stage that advances while its upstream stage is empty or not presenting data loads valid=0. The data and tag of an invalid stage are don't-care and must not be relied on.
- out_valid, out_tag and state_out are driven directly by the last stage.
- Flush: when flush=1 at a rising edge, all valid bits clear. in_valid is ignored that cycle and in_ready=0. Data registers are left unchanged.
- A held output (out_valid && !out_ready) keeps state_out and out_tag stable until it is accepted.

## Timing
- Reset (reset=0, asynchronous):
  - All valid bits, data and tags clear to 0.
  - out_valid=0, state_out=0, out_tag=0.
  - in_ready=1, provided flush=0.
- Latency: a state accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES−1. For PIPE_STAGES=1 it appears in the cycle immediately following the accepting edge.
- Stall: with out_ready=0 and all stages valid, in_ready=0 in the same cycle.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: the output is consumed and the input is accepted on the same edge, with no loss.
- Flush coincident with out_ready=1: the output is counted as consumed and the pipeline still clears.
- Reset asserted mid-transaction: in-flight states are discarded. The first edge after deassertion behaves as from empty.

## Configuration
- SHIFT_ROWS_PIPE_INV_EN:
  - Defined: in_inv selects the inverse permutation per transaction, as above.
  - Undefined: the inverse datapath is not built, in_inv is ignored, and every transaction uses the forward permutation. The port remains present.

## Test plan
- Forward vector (NB=4, PIPE_STAGES=1, in_inv=0): state_in=128'h3052411e_e55db4b8_f198bfe0_ae1127d4 with tag 4'h5 -> next cycle out_valid=1, state_out=128'he598271e_f11141b8_ae52b4e0_305dbfd4, out_tag=4'h5.
- Inverse round-trip (macro defined): feed the forward output above with in_inv=1 -> the original 128'h3052411e_… is returned. With the macro undefined, the same stimulus returns the forward permutation of the input.
- NB=8 offsets: state_in bytes k=0..31 set to value k -> row 1 output column 0 holds byte 5, row 2 holds byte 14 (column 3), row 3 holds byte 19 (column 4).
- Backpressure (PIPE_STAGES=3): stream 10 tagged states with out_ready toggling 1,0,0,1… -> all 10 are delivered in order with correct tags. in_ready falls only once 3 states are held. Output stays stable while stalled.
- Flush: load 2 states into a PIPE_STAGES=3 pipe and pulse flush -> out_valid=0 on the following cycle, in_ready=0 during the flush cycle, and the flushed states are never output.
- Async reset mid-stream: assert reset between edges -> out_valid and state_out go to 0 immediately. After release, a new input emerges with the nominal latency.
